// File: rtl/fir_pkg.sv
// Shared state encoding and compile-time sizing helpers for the serial symmetric FIR.
// Everything here is elaborated away; there is no logic of its own.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    function automatic int fir_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int fir_n_uniq(input int n);
        return (n + 1) / 2;
    endfunction

    // At least one address bit so N=2 (a single unique coefficient) still has a legal port.
    function automatic int fir_aw(input int n);
        int aw;
        aw = fir_clog2(fir_n_uniq(n));
        return (aw < 1) ? 1 : aw;
    endfunction

    function automatic int fir_acc_w(input int dw, input int cw, input int n);
        return dw + 1 + cw + fir_aw(n);
    endfunction

endpackage

// File: rtl/fir_tap_mac.sv
// Shared datapath: pre-add of a mirrored sample pair (or the odd middle sample alone), multiply, accumulate.
// Latency: acc_nxt is combinational; acc registers it on the next enabled edge, clr zeroes it.
// No backpressure: en and clr are sequenced entirely by the owning controller.
module fir_tap_mac
    import fir_pkg::*;
#(
    parameter int DW    = 18,
    parameter int CW    = 18,
    parameter int ACC_W = fir_acc_w(18, 18, 18)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    mid,
    input  logic signed [DW-1:0]    xa,
    input  logic signed [DW-1:0]    xb,
    input  logic signed [CW-1:0]    coef,
    output logic signed [ACC_W-1:0] acc_nxt
);

    logic signed [DW:0]       pre;
    logic signed [DW+CW:0]    prod;
    logic signed [ACC_W-1:0]  acc;

    always_comb begin
        if (mid) begin
            pre = {xa[DW-1], xa};
        end else begin
            pre = {xa[DW-1], xa} + {xb[DW-1], xb};
        end
        prod    = pre * coef;
        acc_nxt = acc + {{(ACC_W-DW-CW-1){prod[DW+CW]}}, prod};
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/fir_sym_serial.sv
// Symmetric FIR, one shared MAC stepping over ceil(N/2) unique taps; FIR_SATURATE_EN clamps instead of wrapping.
// Latency: accept to o_valid is N_UNIQ edges; one sample per N_UNIQ+2 cycles with o_ready high.
// Backpressure: i_ready only in IDLE; result held in OUT until o_ready; clk_ena low freezes everything.
module fir_sym_serial
    import fir_pkg::*;
#(
    parameter int DW    = 18,
    parameter int CW    = 18,
    parameter int N     = 18,
    parameter int SCALE = 17
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_ena,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic signed [DW-1:0]    i_in,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic signed [DW-1:0]    o_out,
    input  logic                    coef_wr,
    input  logic [fir_aw(N)-1:0]    coef_addr,
    input  logic signed [CW-1:0]    coef_data,
    output logic                    busy
);

    localparam int N_UNIQ = fir_n_uniq(N);
    localparam int AW     = fir_aw(N);
    localparam int XW     = fir_clog2(N);
    localparam int ACC_W  = fir_acc_w(DW, CW, N);

    fir_state_t               state;
    logic [AW-1:0]            k;
    logic signed [DW-1:0]     x [N];
    logic signed [CW-1:0]     c [N_UNIQ];
    logic [XW-1:0]            ka;
    logic [XW-1:0]            kb;
    logic                     accept;
    logic                     last;
    logic                     mid;
    logic                     coef_we;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DW-1:0]     res;

    assign i_ready = (state == IDLE);
    assign busy    = (state == MAC) || (state == OUT);
    assign accept  = i_valid && i_ready && clk_ena;
    assign last    = (k == AW'(N_UNIQ - 1));
    assign mid     = last && (N % 2 == 1);
    assign ka      = XW'(k);
    assign kb      = XW'(N - 1) - ka;
    assign coef_we = coef_wr && clk_ena && (state == IDLE)
                     && ({1'b0, coef_addr} < (AW+1)'(N_UNIQ));

    fir_tap_mac #(
        .DW    (DW),
        .CW    (CW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .en      (clk_ena && (state == MAC)),
        .clr     (accept),
        .mid     (mid),
        .xa      (x[ka]),
        .xb      (x[kb]),
        .coef    (c[k]),
        .acc_nxt (acc_nxt)
    );

    // The result is formed from acc_nxt so the last tap lands in o_out on the same edge.
    assign shifted = acc_nxt >>> SCALE;

`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    always_comb begin
        if (shifted > SAT_MAX) begin
            res = SAT_MAX[DW-1:0];
        end else if (shifted < SAT_MIN) begin
            res = SAT_MIN[DW-1:0];
        end else begin
            res = shifted[DW-1:0];
        end
    end
`else
    assign res = shifted[DW-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            k       <= '0;
            o_valid <= 1'b0;
            o_out   <= '0;
            for (int i = 0; i < N; i++) x[i] <= '0;
            for (int i = 0; i < N_UNIQ; i++) c[i] <= '0;
        end else if (clk_ena) begin
            if (coef_we) begin
                c[coef_addr] <= coef_data;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        x[0] <= i_in;
                        for (int i = 1; i < N; i++) x[i] <= x[i-1];
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    k <= k + 1'b1;
                    if (last) begin
                        state   <= OUT;
                        o_valid <= 1'b1;
                        o_out   <= res;
                    end
                end
                OUT: begin
                    if (o_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sym_serial.sv
// Bench for fir_sym_serial: N=18 and N=5 instances against a direct-form convolution model.
`timescale 1ns/1ps
module tb_fir_sym_serial;

    localparam int DW = 18;
    localparam int CW = 18;
    localparam int NA = 18;
    localparam int NB = 5;
    localparam int NUA = 9;
    localparam int NUB = 3;
    localparam int SCALE = 0;
    localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DW - 1));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clk_ena;
    logic a_reset, a_i_valid, a_i_ready, a_o_valid, a_o_ready, a_coef_wr, a_busy;
    logic signed [DW-1:0] a_i_in, a_o_out;
    logic signed [CW-1:0] a_coef_data;
    logic [3:0] a_coef_addr;
    logic b_reset, b_i_valid, b_i_ready, b_o_valid, b_o_ready, b_coef_wr, b_busy;
    logic signed [DW-1:0] b_i_in, b_o_out;
    logic signed [CW-1:0] b_coef_data;
    logic [1:0] b_coef_addr;

    fir_sym_serial #(.DW(DW), .CW(CW), .N(NA), .SCALE(SCALE)) dut_a (
        .clk(clk), .reset(a_reset), .clk_ena(clk_ena),
        .i_valid(a_i_valid), .i_ready(a_i_ready), .i_in(a_i_in),
        .o_valid(a_o_valid), .o_ready(a_o_ready), .o_out(a_o_out),
        .coef_wr(a_coef_wr), .coef_addr(a_coef_addr), .coef_data(a_coef_data),
        .busy(a_busy)
    );

    fir_sym_serial #(.DW(DW), .CW(CW), .N(NB), .SCALE(SCALE)) dut_b (
        .clk(clk), .reset(b_reset), .clk_ena(clk_ena),
        .i_valid(b_i_valid), .i_ready(b_i_ready), .i_in(b_i_in),
        .o_valid(b_o_valid), .o_ready(b_o_ready), .o_out(b_o_out),
        .coef_wr(b_coef_wr), .coef_addr(b_coef_addr), .coef_data(b_coef_data),
        .busy(b_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Reference: h[0] is the newest sample, plain convolution with mirrored coefficients.
    longint ah[$], ac[$], bh[$], bc[$];
    longint a_exp;
    longint a_wdat;
    bit     a_pend;
    bit     run_a;

    function automatic longint fit_dw(input longint s);
        longint r;
`ifdef FIR_SATURATE_EN
        if (s > MAXV) r = MAXV;
        else if (s < MINV) r = MINV;
        else r = s;
`else
        r = s & ((longint'(1) <<< DW) - 1);
        if (r > MAXV) r = r - (longint'(1) <<< DW);
`endif
        return r;
    endfunction

    function automatic longint ref_out(input int n, input longint h[$], input longint c[$]);
        longint acc;
        acc = 0;
        for (int t = 0; t < n; t++) begin
            acc += h[t] * c[(t < (n + 1) / 2) ? t : n - 1 - t];
        end
        return fit_dw(acc >>> SCALE);
    endfunction

    task automatic model_reset_a();
        ah.delete();
        ac.delete();
        for (int i = 0; i < NA; i++) ah.push_back(0);
        for (int i = 0; i < NUA; i++) ac.push_back(0);
    endtask

    always @(negedge clk) begin
        if (run_a) begin
            chk("a_busy", a_busy, a_pend);
            chk("a_i_ready", a_i_ready, !a_pend);
            if (a_pend) begin
                if (a_o_valid) chk("a_o_out", a_o_out, a_exp);
            end else begin
                chk("a_o_valid_idle", a_o_valid, 0);
            end
        end
    end

    task automatic a_wr(input int addr, input longint d);
        a_coef_wr = 1'b1;
        a_coef_addr = addr[3:0];
        a_coef_data = d[CW-1:0];
        @(posedge clk); #1;
        a_coef_wr = 1'b0;
        if (addr < NUA) ac[addr] = d;
    endtask

    // mode: 0 plain, 1 clk_ena gap mid-MAC, 2 o_ready held low, 3 coef write during MAC,
    //       4 reset at k=3, 5 coef write on the accept edge
    task automatic a_send(input longint v, input int mode, output longint got);
        int t;
        int lat;
        got = 0;
        t = 0;
        while (!a_i_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) timeout("a_wait_ready");
        a_i_valid = 1'b1;
        a_i_in = v[DW-1:0];
        if (mode == 5) begin
            a_coef_wr = 1'b1; a_coef_addr = 4'd0; a_coef_data = a_wdat[CW-1:0];
        end
        @(posedge clk); #1;
        a_i_valid = 1'b0;
        a_coef_wr = 1'b0;
        if (mode == 5) ac[0] = a_wdat;
        ah.push_front(v);
        void'(ah.pop_back());
        a_exp = ref_out(NA, ah, ac);
        a_pend = 1'b1;
        if (mode == 4) begin
            repeat (3) begin @(posedge clk); #1; end
            a_reset = 1'b1;
            @(posedge clk); #1;
            chk("rst_o_valid", a_o_valid, 0);
            chk("rst_o_out", a_o_out, 0);
            chk("rst_i_ready", a_i_ready, 1);
            chk("rst_busy", a_busy, 0);
            a_reset = 1'b0;
            a_pend = 1'b0;
            model_reset_a();
            return;
        end
        if (mode == 2) a_o_ready = 1'b0;
        lat = 0;
        while (!a_o_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (mode == 1 && lat == 2) clk_ena = 1'b0;
            if (mode == 1 && lat == 6) clk_ena = 1'b1;
            if (mode == 3 && lat == 1) begin
                a_coef_wr = 1'b1; a_coef_addr = 4'd0; a_coef_data = 18'sd500;
            end
            if (mode == 3 && lat == 2) a_coef_wr = 1'b0;
        end
        chk("a_latency", lat, NUA + ((mode == 1) ? 4 : 0));
        got = a_o_out;
        if (mode == 2) begin
            a_i_valid = 1'b1;
            a_i_in = 18'sd12345;
            repeat (7) begin
                @(posedge clk); #1;
                chk("a_hold_valid", a_o_valid, 1);
            end
            a_i_valid = 1'b0;
            a_o_ready = 1'b1;
        end
        @(posedge clk); #1;
        a_pend = 1'b0;
    endtask

    task automatic a_flush();
        longint g;
        for (int i = 0; i < NA; i++) a_send(0, 0, g);
    endtask

    task automatic b_wr(input int addr, input longint d);
        b_coef_wr = 1'b1;
        b_coef_addr = addr[1:0];
        b_coef_data = d[CW-1:0];
        @(posedge clk); #1;
        b_coef_wr = 1'b0;
        if (addr < NUB) bc[addr] = d;
    endtask

    task automatic b_send(input longint v, output longint got);
        int lat;
        b_i_valid = 1'b1;
        b_i_in = v[DW-1:0];
        @(posedge clk); #1;
        b_i_valid = 1'b0;
        bh.push_front(v);
        void'(bh.pop_back());
        lat = 0;
        while (!b_o_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("b_latency", lat, NUB);
        got = b_o_out;
        chk("b_o_out", got, ref_out(NB, bh, bc));
        @(posedge clk); #1;
        chk("b_i_ready", b_i_ready, 1);
    endtask

    function automatic longint rnd18();
        return longint'($urandom_range(0, 262143)) - 131072;
    endfunction

    initial begin
        longint got;
        int modes[4];
        longint b_lit[6];
        modes = '{0, 1, 2, 5};
        b_lit = '{10, 30, 60, 80, 90, 90};
        a_reset = 1'b1; b_reset = 1'b1; clk_ena = 1'b0;
        a_i_valid = 1'b0; a_i_in = '0; a_o_ready = 1'b1;
        a_coef_wr = 1'b0; a_coef_addr = '0; a_coef_data = '0;
        b_i_valid = 1'b0; b_i_in = '0; b_o_ready = 1'b1;
        b_coef_wr = 1'b0; b_coef_addr = '0; b_coef_data = '0;
        a_pend = 1'b0; run_a = 1'b0; a_exp = 0; a_wdat = 0;
        model_reset_a();
        for (int i = 0; i < NB; i++) bh.push_back(0);
        for (int i = 0; i < NUB; i++) bc.push_back(0);
        repeat (3) @(posedge clk);
        #1;
        // reset must win even with clk_ena low
        chk("reset_i_ready", a_i_ready, 1);
        chk("reset_o_valid", a_o_valid, 0);
        chk("reset_o_out", a_o_out, 0);
        chk("reset_busy", a_busy, 0);
        a_reset = 1'b0; b_reset = 1'b0; clk_ena = 1'b1;
        run_a = 1'b1;

        a_wr(0, 88);
        a_wr(9, 777);
        a_send(1, 0, got);
        chk("imp_0", got, 88);
        for (int i = 1; i < NA + 1; i++) begin
            a_send(0, 0, got);
            if (i == NA - 1) chk("imp_17", got, 88);
            else if (i == 1 || i == NA) chk("imp_zero", got, 0);
        end

        a_send(4, 3, got);
        a_flush();
        a_send(1, 0, got);
        chk("coef_mac_ignored", got, 88);

        a_send(5, 2, got);
        a_send(7, 1, got);
        a_send(-9, 2, got);
        a_wdat = -3;
        a_send(2, 5, got);
        a_send(6, 0, got);

        for (int i = 1; i < NUA; i++) a_wr(i, 0);
        a_wr(0, 131071);
        a_flush();
        a_send(131071, 0, got);
`ifdef FIR_SATURATE_EN
        chk("sat_first", got, 131071);
`else
        chk("wrap_first", got, 1);
`endif
        for (int i = 1; i < NA; i++) a_send(131071, 0, got);
`ifdef FIR_SATURATE_EN
        chk("sat_full", got, 131071);
`else
        chk("wrap_full", got, 2);
`endif

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NUA; i++) a_wr(i, rnd18() >>> $urandom_range(0, 14));
            for (int i = 0; i < 15; i++) begin
                a_wdat = rnd18() >>> 8;
                a_send(rnd18() >>> $urandom_range(0, 12), modes[$urandom_range(0, 3)], got);
            end
        end

        a_send(9, 4, got);
        a_send(rnd18(), 0, got);
        chk("post_reset_zero", got, 0);
        a_wr(1, 3);
        a_send(100, 0, got);
        a_send(0, 0, got);
        chk("post_reset_c1", got, 300);
        run_a = 1'b0;

        b_wr(0, 1); b_wr(1, 2); b_wr(2, 3); b_wr(3, 99);
        for (int i = 0; i < 6; i++) begin
            b_send(10, got);
            chk("b_const", got, b_lit[i]);
        end
        for (int i = 0; i < NUB; i++) b_wr(i, rnd18());
        for (int i = 0; i < 12; i++) b_send(rnd18(), got);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
